// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: cache line, physical-memory beat, beat index
// and the line adaptor state encoding.
package lc3b_types;

    localparam int LINE_WIDTH      = 128;
    localparam int BEAT_WIDTH      = 32;
    localparam int LC3B_LINE_BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int BEAT_IDX_W      = $clog2(LC3B_LINE_BEATS);
    localparam int ADDR_W          = 16;
    localparam int LINE_OFFSET_W   = $clog2(LINE_WIDTH / 8);
    localparam int BEAT_OFFSET_W   = $clog2(BEAT_WIDTH / 8);

    typedef logic [LINE_WIDTH-1:0]               lc3b_c_line;
    typedef logic [BEAT_WIDTH-1:0]               lc3b_pmem_beat;
    typedef logic [BEAT_IDX_W-1:0]               lc3b_beat_idx;
    typedef logic [ADDR_W-1:0]                   lc3b_addr;
    typedef logic [ADDR_W-LINE_OFFSET_W-1:0]     lc3b_line_tag;
    typedef logic [LC3B_LINE_BEATS-1:0][BEAT_WIDTH-1:0] lc3b_beat_arr;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } cla_state_e;

    localparam lc3b_beat_idx LAST_BEAT = lc3b_beat_idx'(LC3B_LINE_BEATS - 1);

    // Byte address of one beat inside a line: beats ascend by one beat width.
    function automatic lc3b_addr beat_addr(input lc3b_line_tag tag, input lc3b_beat_idx idx);
        return {tag, idx, {BEAT_OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Line storage shared by fill and write-back: beat-indexed fill register and a
// victim register with a beat-indexed read mux.
module line_beat_buffer
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fill_en,
    input  lc3b_beat_idx  fill_idx,
    input  lc3b_pmem_beat fill_beat,
    input  logic          load_en,
    input  lc3b_c_line    load_line,
    input  lc3b_beat_idx  rd_idx,
    output lc3b_c_line    fill_line,
    output lc3b_pmem_beat rd_beat
);

    lc3b_beat_arr fill_q;
    lc3b_beat_arr victim_q;

    // The fill line only changes one beat at a time; the victim line is captured whole at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q   <= '0;
            victim_q <= '0;
        end else begin
            if (fill_en) begin
                fill_q[fill_idx] <= fill_beat;
            end
            if (load_en) begin
                victim_q <= load_line;
            end
        end
    end

    assign fill_line = fill_q;
    assign rd_beat   = victim_q[rd_idx];

endmodule

// File: rtl/cache_line_adaptor.sv
// Splits a 128-bit cache line fill or write-back into four 32-bit physical
// memory beats and signals completion with a one-cycle line_resp pulse.
module cache_line_adaptor
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          line_read,
    input  logic          line_write,
    input  logic [15:0]   line_addr,
    input  lc3b_c_line    line_wdata,
    output lc3b_c_line    line_rdata,
    output logic          line_resp,
    output logic          pmem_read,
    output logic          pmem_write,
    output logic [15:0]   pmem_address,
    output lc3b_pmem_beat pmem_wdata,
    input  lc3b_pmem_beat pmem_rdata,
    input  logic          pmem_resp
);

    cla_state_e    state_q;
    lc3b_beat_idx  cnt_q;
    lc3b_line_tag  tag_q;

    logic          fill_en_s;
    logic          load_en_s;
    lc3b_pmem_beat victim_beat_s;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^line_addr[LINE_OFFSET_W-1:0];

    // Line FSM: write has priority over read when both are requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (line_write) begin
                        tag_q   <= line_addr[ADDR_W-1:LINE_OFFSET_W];
                        cnt_q   <= '0;
                        state_q <= ST_WRITE;
                    end else if (line_read) begin
                        tag_q   <= line_addr[ADDR_W-1:LINE_OFFSET_W];
                        cnt_q   <= '0;
                        state_q <= ST_READ;
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (pmem_resp) begin
                        cnt_q <= cnt_q + lc3b_beat_idx'(1);
                        if (cnt_q == LAST_BEAT) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign fill_en_s = (state_q == ST_READ) && pmem_resp;
    assign load_en_s = (state_q == ST_IDLE) && line_write;

    line_beat_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill_en   (fill_en_s),
        .fill_idx  (cnt_q),
        .fill_beat (pmem_rdata),
        .load_en   (load_en_s),
        .load_line (line_wdata),
        .rd_idx    (cnt_q),
        .fill_line (line_rdata),
        .rd_beat   (victim_beat_s)
    );

    // Every output below depends only on registers, never on the line_*/pmem_* inputs.
    assign pmem_read    = (state_q == ST_READ);
    assign pmem_write   = (state_q == ST_WRITE);
    assign line_resp    = (state_q == ST_DONE);
    assign pmem_address = (pmem_read || pmem_write) ? beat_addr(tag_q, cnt_q) : 16'h0000;
    assign pmem_wdata   = pmem_write ? victim_beat_s : 32'h0000_0000;

endmodule

// File: doc/cache_line_adaptor.md
Name: cache_line_adaptor

Overview:
- Sits directly downstream of cache_control and the cache datapath, between the cache and physical memory.
- Turns one 128-bit line fill (allocate) or line write-back into a sequence of 32-bit beat transactions on the physical memory port.
- Returns the assembled line with a single-cycle line_resp pulse.
- The cache side issues at most one line operation at a time.

Parameters:
- LINE_WIDTH, 128: cache line width in bits.
- BEAT_WIDTH, 32: physical memory data width in bits.
- BEATS, LINE_WIDTH/BEAT_WIDTH = 4: beats per line. Must be a power of 2.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- line_read  in  1  cache requests a line fill. Held until line_resp.
- line_write  in  1  cache requests a line write-back. Held until line_resp.
- line_addr  in  16  byte address of the line. Bits [3:0] are ignored.
- line_wdata  in  128  victim line to write back.
- line_rdata  out  128  assembled fill line.
- line_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  beat read request.
- pmem_write  out  1  beat write request.
- pmem_address  out  16  beat byte address.
- pmem_wdata  out  32  beat write data.
- pmem_rdata  in  32  beat read data. Valid when pmem_resp=1 during a read.
- pmem_resp  in  1  current beat complete. Memory may insert any number of wait cycles.

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately forces the state to IDLE and clears the beat counter, the address, data, line_rdata and line_resp. pmem_read, pmem_write, pmem_address and pmem_wdata go to 0.
- Reset mid-operation aborts the current line. Partial data is discarded and no line_resp is issued.
- States and transitions:
  - IDLE: if line_write=1, latch line_addr[15:4] and line_wdata, clear the counter, go to WRITE. Otherwise, if line_read=1, latch the address, clear the counter, go to READ. Both requests high is illegal; write takes priority.
  - READ: pmem_read=1. When pmem_resp=1, store pmem_rdata into line_rdata[BEAT_WIDTH*cnt +: BEAT_WIDTH] and increment cnt. Go to DONE when cnt=BEATS-1 and pmem_resp=1.
  - WRITE: pmem_write=1, pmem_wdata = latched data slice for cnt. When pmem_resp=1, increment cnt. Go to DONE on the last beat.
  - DONE: line_resp=1 for exactly one cycle, then return to IDLE.
- pmem_address = {latched_addr[15:4], cnt, 2'b00}: beats are issued in ascending order, +4 bytes per beat.
- The line address and write data are captured once at acceptance. Changes on the line_* inputs during READ or WRITE are ignored.
- pmem_resp is ignored in IDLE and DONE.
- cnt is 2 bits and wraps 3->0 only on the final beat. It is never observable outside READ and WRITE.
- line_rdata holds the last completed fill until the next read beat 0 overwrites slice 0. A write-back does not modify line_rdata.
- Latency with zero-wait memory (pmem_resp=1 on the first cycle of each beat): line_resp goes high 5 cycles after the edge that accepts the request. Each wait cycle adds one cycle.
- A request still asserted in the cycle after DONE is accepted as a new operation. cache_control must drop its request on the line_resp edge.
- pmem_read and pmem_write are never both 1. Both are 0 in IDLE and DONE.
- All pmem_* outputs and line_resp are decoded from registered state, so there is no combinational path from line_* or pmem_* inputs to outputs.

Decomposition:
- Add the following to lc3b_types:
  - lc3b_c_line: 128-bit line type.
  - lc3b_pmem_beat: 32-bit beat type.
  - lc3b_beat_idx: 2-bit beat index type.
  - Constant LC3B_LINE_BEATS = 4.
- The FSM and counter stay in cache_line_adaptor.
- Sub-module line_beat_buffer holds the 128-bit line register. It provides beat-indexed write (fill) and beat-indexed read mux (write-back) and is shared by both directions.

Test Plan:
- Reset check: hold rst_n=0 with line_read=1 -> all outputs 0. Release reset -> accepted next edge.
- Read fill, zero-wait, line_addr=0x1234, pmem_rdata = 0xAAAA0000+beat -> addresses 0x1230, 0x1234, 0x1238, 0x123C. line_rdata = {0xAAAA0003, 0xAAAA0002, 0xAAAA0001, 0xAAAA0000}. line_resp one cycle, 5 cycles after accept.
- Write-back, line_wdata = 0x44444444_33333333_22222222_11111111, line_addr=0x8000, 2 wait cycles per beat -> pmem_wdata 0x11111111..0x44444444 in order at 0x8000..0x800C. line_resp after 13 cycles. line_rdata unchanged.
- line_read and line_write both 1 -> WRITE sequence only. line_addr changed to 0xFFF0 mid-line -> addresses still from the latched base.
- rst_n pulsed low during beat 2 of a read -> pmem_read drops immediately, no line_resp. A new read afterwards restarts at beat 0.
- Back-to-back: write-back 0x2000 then read 0x3000 with the read asserted in the cycle after line_resp -> second operation starts, and each op gets exactly one line_resp pulse.
